// File: rtl/slide_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// slide_sequencer_pkg
// Shared slideshow/VGA definitions. The renderer and the slide sequencer both
// import this package, so the two agree on the ROM layout and the sequencer
// state encoding.
//   NUM_SLIDES   : images stored in ROM; the slide index wraps modulo this value
//   SLIDE_PIXELS : ROM words per image
//   state_e      : 2-bit sequencer FSM encoding
// -----------------------------------------------------------------------------
package slide_sequencer_pkg;

  localparam int NUM_SLIDES   = 4;
  localparam int SLIDE_PIXELS = 15000;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE_ENC = 2'd1;
  localparam logic [1:0] ST_PENDING_ENC  = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_DEBOUNCE = ST_DEBOUNCE_ENC,
    ST_PENDING  = ST_PENDING_ENC,
    ST_HOLD     = ST_HOLD_ENC
  } state_e;

endpackage

// File: rtl/slide_btn_sync.sv
// -----------------------------------------------------------------------------
// slide_btn_sync
// Two-flop synchronizer for the asynchronous board buttons. Each bit gets its
// own two-stage chain, and both stages clear to 0 on reset.
//   clk    in  pixel clock
//   reset  in  asynchronous, active-high
//   i_btn  in  raw button levels (asynchronous)
//   o_btn  out synchronized button levels (2-edge latency)
// -----------------------------------------------------------------------------
module slide_btn_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_btn
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments make both stages sample their old values,
  // which keeps this a two-flop chain instead of collapsing it into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  assign o_btn = r_sync;

endmodule

// File: rtl/slide_sequencer.sv
// -----------------------------------------------------------------------------
// slide_sequencer
// Sequences the slideshow. It synchronizes and debounces the next/previous
// buttons, keeps the current slide index, and applies each step only on
// frame_start so that the renderer never changes image in the middle of a
// frame. It also drives the ROM base address for the current slide, which is
// slide_index*SLIDE_PIXELS. That address is maintained by adding or subtracting
// SLIDE_PIXELS, so no multiplier is needed.
//   clk          in  pixel clock
//   reset        in  asynchronous, active-high; clears all state
//   nextIMG      in  raw next button (asynchronous)
//   previousIMG  in  raw previous button (asynchronous)
//   frame_start  in  one-cycle pulse at the start of vertical blanking
//   auto_en      in  auto-advance request (used only with SLIDE_AUTO_ADVANCE_EN)
//   slide_index  out current slide
//   base_addr    out ROM base address of the current slide
//   step_pulse   out one-cycle pulse aligned with a slide_index change
//   pending      out a debounced step is waiting for frame_start
// Optional feature macro: SLIDE_AUTO_ADVANCE_EN. When it is defined, the
// sequencer advances one slide every AUTO_FRAMES frames while idle and
// auto_en=1.
// -----------------------------------------------------------------------------
module slide_sequencer #(
  parameter int NUM_SLIDES      = slide_sequencer_pkg::NUM_SLIDES,
  parameter int SLIDE_PIXELS    = slide_sequencer_pkg::SLIDE_PIXELS,
  parameter int ADDR_W          = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          nextIMG,
  input  logic                          previousIMG,
  input  logic                          frame_start,
  input  logic                          auto_en,
  output logic [$clog2(NUM_SLIDES)-1:0] slide_index,
  output logic [ADDR_W-1:0]             base_addr,
  output logic                          step_pulse,
  output logic                          pending
);

  import slide_sequencer_pkg::*;

  localparam int IDX_W = $clog2(NUM_SLIDES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLIDES - 1);
  localparam logic [ADDR_W-1:0] STEP_ADDR = ADDR_W'(SLIDE_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_SLIDES - 1) * SLIDE_PIXELS);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] w_btn_sync;
  logic       w_nx;
  logic       w_pv;
  logic       w_latched_btn;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_dir_up;
  logic              w_dir_up_nxt;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_cnt_nxt;
  logic              w_manual_step;
  logic              w_step;
  logic              w_step_up;

  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic              r_step_pulse;

  slide_btn_sync #(.WIDTH(2)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .i_btn ({previousIMG, nextIMG}),
    .o_btn (w_btn_sync)
  );

  assign w_nx          = w_btn_sync[0];
  assign w_pv          = w_btn_sync[1];
  assign w_latched_btn = r_dir_up ? w_nx : w_pv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dir_up <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir_up <= w_dir_up_nxt;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first. Without the
  // defaults, a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_up_nxt  = r_dir_up;
    w_db_cnt_nxt  = r_db_cnt;
    w_manual_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Exactly one button is needed. Both held together is ambiguous and ignored.
        if (w_nx ^ w_pv) begin
          w_dir_up_nxt = w_nx;
          w_db_cnt_nxt = '0;
          w_state_nxt  = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_latched_btn) begin
          w_state_nxt = ST_IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = ST_PENDING;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          w_manual_step = 1'b1;
          w_state_nxt   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Returning to IDLE only after a full release gives one step per press.
        if (!w_nx && !w_pv) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SLIDE_AUTO_ADVANCE_EN
  localparam int AF_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTO_FRAMES - 1);

  logic [AF_W-1:0] r_frame_cnt;
  logic            w_auto_step;

  assign w_auto_step = (r_state == ST_IDLE) && auto_en && frame_start &&
                       (r_frame_cnt == AF_LAST);

  // Frames are counted only while idle. In the other states the count holds,
  // and a manual step restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (!auto_en || w_manual_step || w_auto_step) begin
      r_frame_cnt <= '0;
    end else if ((r_state == ST_IDLE) && frame_start) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // A manual step happens only in PENDING and an auto step only in IDLE, so
  // the two can never coincide.
  assign w_step    = w_manual_step | w_auto_step;
  assign w_step_up = w_auto_step ? 1'b1 : r_dir_up;
`else
  logic w_unused_auto_en;
  assign w_unused_auto_en = auto_en;
  assign w_step           = w_manual_step;
  assign w_step_up        = r_dir_up;
`endif

  // The index and base address are updated together, so base_addr always
  // matches slide_index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_base       <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      if (w_step) begin
        if (w_step_up) begin
          if (r_idx == LAST_IDX) begin
            r_idx  <= '0;
            r_base <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
            r_base <= r_base + STEP_ADDR;
          end
        end else begin
          if (r_idx == '0) begin
            r_idx  <= LAST_IDX;
            r_base <= LAST_BASE;
          end else begin
            r_idx  <= r_idx - 1'b1;
            r_base <= r_base - STEP_ADDR;
          end
        end
      end
    end
  end

  assign slide_index = r_idx;
  assign base_addr   = r_base;
  assign step_pulse  = r_step_pulse;
  assign pending     = (r_state == ST_PENDING);

endmodule

// File: tb/tb_slide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slide_sequencer
// Directed testbench for slide_sequencer, configured with DEBOUNCE_CYCLES=4,
// AUTO_FRAMES=3, NUM_SLIDES=4 and SLIDE_PIXELS=15000. Inputs change 1 ns after
// each rising edge, and outputs are checked at that same point.
// The auto-advance steps run only when SLIDE_AUTO_ADVANCE_EN is defined.
// -----------------------------------------------------------------------------
module tb_slide_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        nextIMG;
  logic        previousIMG;
  logic        frame_start;
  logic        auto_en;
  logic [1:0]  slide_index;
  logic [15:0] base_addr;
  logic        step_pulse;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int bad      = 0;

  slide_sequencer #(
    .NUM_SLIDES      (4),
    .SLIDE_PIXELS    (15000),
    .ADDR_W          (16),
    .DEBOUNCE_CYCLES (4),
    .AUTO_FRAMES     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nextIMG     (nextIMG),
    .previousIMG (previousIMG),
    .frame_start (frame_start),
    .auto_en     (auto_en),
    .slide_index (slide_index),
    .base_addr   (base_addr),
    .step_pulse  (step_pulse),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Count the number of cycles step_pulse is high. A single step must add exactly one.
  always @(negedge clk) if (step_pulse === 1'b1) n_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic release_btns();
    nextIMG     = 1'b0;
    previousIMG = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; nextIMG = 1'b0; previousIMG = 1'b0;
    frame_start = 1'b0; auto_en = 1'b0;
    repeat (3) tick();
    check("rst_index", {30'd0, slide_index}, 32'd0);
    check("rst_base", {16'd0, base_addr}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_step", {31'd0, step_pulse}, 32'd0);
    reset = 1'b0;
    tick();

    // Next is held for 10 cycles and debounces into PENDING. The frame then steps 0->1.
    nextIMG = 1'b1;
    repeat (10) tick();
    check("next1_pending", {31'd0, pending}, 32'd1);
    frame();
    check("next1_index", {30'd0, slide_index}, 32'd1);
    check("next1_base", {16'd0, base_addr}, 32'd15000);
    check("next1_step_hi", {31'd0, step_pulse}, 32'd1);
    tick();
    check("next1_step_lo", {31'd0, step_pulse}, 32'd0);
    // Holding the button through three more frames gives no further step.
    for (int i = 0; i < 3; i++) begin
      repeat (5) tick();
      frame();
    end
    check("hold_index", {30'd0, slide_index}, 32'd1);
    check("hold_pulses", n_pulses, 32'd1);
    release_btns();

    // A 3-cycle press never completes debounce.
    nextIMG = 1'b1;
    repeat (3) tick();
    nextIMG = 1'b0;
    repeat (6) tick();
    check("short_pending", {31'd0, pending}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      frame();
      repeat (3) tick();
    end
    check("short_index", {30'd0, slide_index}, 32'd1);
    check("short_pulses", n_pulses, 32'd1);

    // A second next press steps 1->2.
    nextIMG = 1'b1;
    repeat (10) tick();
    frame();
    check("next2_index", {30'd0, slide_index}, 32'd2);
    check("next2_base", {16'd0, base_addr}, 32'd30000);
    release_btns();

    // Reset is applied while in PENDING at index 2.
    nextIMG = 1'b1;
    repeat (10) tick();
    check("pre_rst_pending", {31'd0, pending}, 32'd1);
    reset = 1'b1;
    nextIMG = 1'b0;
    #1;
    check("midrst_index", {30'd0, slide_index}, 32'd0);
    check("midrst_base", {16'd0, base_addr}, 32'd0);
    check("midrst_pending", {31'd0, pending}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    frame();
    tick();
    check("postrst_index", {30'd0, slide_index}, 32'd0);
    check("postrst_pulses", n_pulses, 32'd2);

    // Previous at index 0 wraps to index 3.
    previousIMG = 1'b1;
    repeat (10) tick();
    frame();
    check("prev_wrap_index", {30'd0, slide_index}, 32'd3);
    check("prev_wrap_base", {16'd0, base_addr}, 32'd45000);
    release_btns();

    // Next at index 3 wraps to index 0.
    nextIMG = 1'b1;
    repeat (10) tick();
    frame();
    check("next_wrap_index", {30'd0, slide_index}, 32'd0);
    check("next_wrap_base", {16'd0, base_addr}, 32'd0);
    release_btns();
    check("wrap_pulses", n_pulses, 32'd4);

    // Pressing both buttons together gives no step.
    nextIMG = 1'b1;
    previousIMG = 1'b1;
    repeat (10) tick();
    check("both_pending", {31'd0, pending}, 32'd0);
    frame();
    release_btns();
    check("both_index", {30'd0, slide_index}, 32'd0);
    check("both_pulses", n_pulses, 32'd4);

    // After debounce, frame_start is withheld for 1000 cycles.
    nextIMG = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pending !== 1'b1 || step_pulse !== 1'b0) bad++;
    end
    check("wait_pending_held", bad, 32'd0);
    check("wait_index", {30'd0, slide_index}, 32'd0);
    frame();
    check("wait_step_index", {30'd0, slide_index}, 32'd1);
    check("wait_step_pulse", {31'd0, step_pulse}, 32'd1);
    check("wait_after_pending", {31'd0, pending}, 32'd0);
    release_btns();

`ifdef SLIDE_AUTO_ADVANCE_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    auto_en = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      frame();
      if (i == 3) begin
        check("auto_f3_index", {30'd0, slide_index}, 32'd1);
        check("auto_f3_step", {31'd0, step_pulse}, 32'd1);
      end
      if (i == 5) check("auto_f5_index", {30'd0, slide_index}, 32'd1);
      repeat (2) tick();
    end
    check("auto_f6_index", {30'd0, slide_index}, 32'd2);
    // Frame 1 advances the count. The manual step on frame 2 then clears it.
    frame();
    repeat (2) tick();
    nextIMG = 1'b1;
    repeat (10) tick();
    frame();
    check("auto_manual_index", {30'd0, slide_index}, 32'd3);
    release_btns();
    frame();
    repeat (2) tick();
    frame();
    repeat (2) tick();
    check("auto_restart_hold", {30'd0, slide_index}, 32'd3);
    frame();
    check("auto_restart_step", {30'd0, slide_index}, 32'd0);
    auto_en = 1'b0;
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
